// File: rtl/alu_control_sequencer_if.sv
// rtl/alu_control_sequencer_if.sv - control-strobe bundle between the sequencer and the CPU datapath.
interface alu_control_sequencer_if #(
  parameter int OPW  = 5,
  parameter int CNTW = 16
);
  logic            run;
  logic [31:0]     IR;
  logic            alu_done;

  logic            PCout, Zlowout, Zhighout, MDRout, Rout;
  logic            MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin;
  logic            IncPC, Read;
  logic            Gra, Grb, Grc;
  logic [OPW-1:0]  alu_op;
  logic            busy, halted, illegal;
  logic [CNTW-1:0] instr_count;

  // master is the sequencer side, slave is the datapath/environment side
  modport master (
    input  run, IR, alu_done,
    output PCout, Zlowout, Zhighout, MDRout, Rout,
           MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
           IncPC, Read, Gra, Grb, Grc, alu_op, busy, halted, illegal, instr_count
  );

  modport slave (
    output run, IR, alu_done,
    input  PCout, Zlowout, Zhighout, MDRout, Rout,
           MARin, PCin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
           IncPC, Read, Gra, Grb, Grc, alu_op, busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - fetch/decode/execute FSM driving datapath strobes for reg-reg ALU ops.
module alu_control_sequencer #(
  parameter int OPW  = 5,
  parameter int CNTW = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  alu_control_sequencer_if.master bus
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t          state_q;
  logic            halted_q;
  logic            illegal_q;
  logic [CNTW-1:0] count_q;

  logic [OPW-1:0]  opcode;
  logic            is_alu, is_muldiv, is_nop, is_halt;
  state_t          retire_state;
  logic            ir_unused;

  assign opcode    = bus.IR[31 -: OPW];
  assign ir_unused = ^bus.IR[31-OPW:0];

  always_comb begin
    is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                (opcode == OP_AND) || (opcode == OP_OR);
    is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    is_nop    = (opcode == OP_NOP);
    is_halt   = (opcode == OP_HALT);
  end

  // run is consulted only here and in IDLE, so dropping it never aborts an instruction
  assign retire_state = bus.run ? S_T0 : S_IDLE;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.run) state_q <= S_T0;
        S_T0:   state_q <= S_T1;
        S_T1:   state_q <= S_T2;
        S_T2:   state_q <= S_T3;
        S_T3: begin
          if (is_alu || is_muldiv) begin
            state_q <= S_T4;
          end else if (is_nop) begin
            count_q <= count_q + 1'b1;
            state_q <= retire_state;
          end else if (is_halt) begin
            count_q  <= count_q + 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end
        end
        S_T4: if (!is_muldiv || bus.alu_done) state_q <= S_T5;
        S_T5: begin
          if (is_muldiv) begin
            state_q <= S_T6;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= retire_state;
          end
        end
        S_T6: begin
          count_q <= count_q + 1'b1;
          state_q <= retire_state;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Rout     = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Rin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.alu_op   = '0;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        // MUL/DIV read the Ra field into Y; two-operand ALU ops read Rb
        bus.Rout = is_alu || is_muldiv;
        bus.Yin  = is_alu || is_muldiv;
        bus.Grb  = is_alu;
        bus.Gra  = is_muldiv;
      end
      S_T4: begin
        bus.Rout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.Grc    = !is_muldiv;
        bus.Grb    = is_muldiv;
        bus.alu_op = opcode;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin    = is_muldiv;
        bus.Gra     = !is_muldiv;
        bus.Rin     = !is_muldiv;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - directed bench for alu_control_sequencer.
module tb_alu_control_sequencer;

  localparam logic [18:0] B_PCOUT  = 19'h40000;
  localparam logic [18:0] B_ZLOW   = 19'h20000;
  localparam logic [18:0] B_ZHIGH  = 19'h10000;
  localparam logic [18:0] B_MDROUT = 19'h08000;
  localparam logic [18:0] B_ROUT   = 19'h04000;
  localparam logic [18:0] B_MARIN  = 19'h02000;
  localparam logic [18:0] B_PCIN   = 19'h01000;
  localparam logic [18:0] B_MDRIN  = 19'h00800;
  localparam logic [18:0] B_IRIN   = 19'h00400;
  localparam logic [18:0] B_YIN    = 19'h00200;
  localparam logic [18:0] B_ZIN    = 19'h00100;
  localparam logic [18:0] B_RIN    = 19'h00080;
  localparam logic [18:0] B_HIIN   = 19'h00040;
  localparam logic [18:0] B_LOIN   = 19'h00020;
  localparam logic [18:0] B_INCPC  = 19'h00010;
  localparam logic [18:0] B_READ   = 19'h00008;
  localparam logic [18:0] B_GRA    = 19'h00004;
  localparam logic [18:0] B_GRB    = 19'h00002;
  localparam logic [18:0] B_GRC    = 19'h00001;

  localparam logic [18:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [18:0] F_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
  localparam logic [18:0] F_T2 = B_MDROUT | B_IRIN;
  localparam logic [18:0] A_T3 = B_GRB | B_ROUT | B_YIN;
  localparam logic [18:0] A_T4 = B_GRC | B_ROUT | B_ZIN;
  localparam logic [18:0] A_T5 = B_ZLOW | B_GRA | B_RIN;
  localparam logic [18:0] X_T3 = B_GRA | B_ROUT | B_YIN;
  localparam logic [18:0] X_T4 = B_GRB | B_ROUT | B_ZIN;
  localparam logic [18:0] X_T5 = B_ZLOW | B_LOIN;
  localparam logic [18:0] X_T6 = B_ZHIGH | B_HIIN;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_fail;

  alu_control_sequencer_if #(.OPW(5), .CNTW(8)) bus ();

  alu_control_sequencer #(.OPW(5), .CNTW(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  logic [18:0] obs;
  assign obs = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Rout,
                bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin,
                bus.Rin, bus.HIin, bus.LOin, bus.IncPC, bus.Read,
                bus.Gra, bus.Grb, bus.Grc};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1; bus.run = 1'b0; bus.IR = 32'h0; bus.alu_done = 1'b0;
    tick(); tick();
    clear = 1'b0;
    n_checks++; if (obs !== 19'd0) begin n_fail++; $display("FAIL reset_strobes: got %h expected 0", obs); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b%b expected 00", bus.halted, bus.illegal); end
    n_checks++; if (bus.instr_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.instr_count); end
    n_checks++; if (bus.alu_op !== 5'd0) begin n_fail++; $display("FAIL reset_alu_op: got %b expected 0", bus.alu_op); end
  endtask

  task automatic test_add();
    logic [18:0] exp_s [0:5];
    logic [4:0]  exp_op;
    exp_s = '{F_T0, F_T1, F_T2, A_T3, A_T4, A_T5};
    bus.IR = 32'h1890_0000; bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) bus.run = 1'b0;
      exp_op = (i == 4) ? 5'b00011 : 5'b00000;
      n_checks++; if (obs !== exp_s[i]) begin n_fail++; $display("FAIL add_strobes_t%0d: got %h expected %h", i, obs, exp_s[i]); end
      n_checks++; if (bus.alu_op !== exp_op) begin n_fail++; $display("FAIL add_alu_op_t%0d: got %b expected %b", i, bus.alu_op, exp_op); end
    end
    tick();
    n_checks++; if (bus.instr_count !== 8'd1) begin n_fail++; $display("FAIL add_count: got %0d expected 1", bus.instr_count); end
    n_checks++; if (bus.busy !== 1'b0 || obs !== 19'd0) begin n_fail++; $display("FAIL add_idle: busy %b strobes %h expected 0/0", bus.busy, obs); end
  endtask

  task automatic test_div_stall();
    logic [18:0] exp_s [0:9];
    logic [4:0]  exp_op;
    exp_s = '{F_T0, F_T1, F_T2, X_T3, X_T4, X_T4, X_T4, X_T4, X_T5, X_T6};
    bus.IR = 32'h8000_0000; bus.run = 1'b1; bus.alu_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_op = (i >= 4 && i <= 7) ? 5'b10000 : 5'b00000;
      n_checks++; if (obs !== exp_s[i]) begin n_fail++; $display("FAIL div_strobes_c%0d: got %h expected %h", i, obs, exp_s[i]); end
      n_checks++; if (bus.alu_op !== exp_op) begin n_fail++; $display("FAIL div_alu_op_c%0d: got %b expected %b", i, bus.alu_op, exp_op); end
      if (i == 1) bus.alu_done = 1'b1;
      if (i == 2) bus.alu_done = 1'b0;
      if (i == 7) bus.alu_done = 1'b1;
      if (i == 8) bus.alu_done = 1'b0;
      if (i == 9) bus.run = 1'b0;
    end
    tick();
    n_checks++; if (bus.instr_count !== 8'd2) begin n_fail++; $display("FAIL div_count: got %0d expected 2", bus.instr_count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div_idle: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_clear_mid_stall();
    bus.IR = 32'h8000_0000; bus.run = 1'b1; bus.alu_done = 1'b0;
    repeat (6) tick();
    n_checks++; if (obs !== X_T4) begin n_fail++; $display("FAIL clr_in_t4: got %h expected %h", obs, X_T4); end
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0; bus.run = 1'b0;
    n_checks++; if (obs !== 19'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle: strobes %h busy %b expected 0/0", obs, bus.busy); end
    n_checks++; if (bus.instr_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", bus.instr_count); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL clr_halted: got %b expected 0", bus.halted); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_stay_idle: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_run_drop();
    logic [18:0] exp_s [0:6];
    exp_s = '{F_T0, F_T1, F_T2, X_T3, X_T4, X_T5, X_T6};
    bus.IR = 32'h7800_0000; bus.run = 1'b1; bus.alu_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 2) bus.run = 1'b0;
      n_checks++; if (obs !== exp_s[i]) begin n_fail++; $display("FAIL mul_strobes_t%0d: got %h expected %h", i, obs, exp_s[i]); end
    end
    tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.instr_count !== 8'd1) begin n_fail++; $display("FAIL mul_drop_idle: busy %b count %0d expected 0/1", bus.busy, bus.instr_count); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_drop_stay: busy %b expected 0", bus.busy); end
    bus.run = 1'b1;
    tick();
    n_checks++; if (obs !== F_T0) begin n_fail++; $display("FAIL mul_rerun_t0: got %h expected %h", obs, F_T0); end
    bus.run = 1'b0;
    repeat (7) tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.instr_count !== 8'd2) begin n_fail++; $display("FAIL mul_second: busy %b count %0d expected 0/2", bus.busy, bus.instr_count); end
  endtask

  task automatic test_illegal();
    bus.IR = 32'hF800_0000; bus.run = 1'b1;
    repeat (4) tick();
    n_checks++; if (obs !== 19'd0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL ill_t3: strobes %h halted %b expected 0/0", obs, bus.halted); end
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flags: got %b%b expected 11", bus.halted, bus.illegal); end
    n_checks++; if (bus.instr_count !== 8'd2) begin n_fail++; $display("FAIL ill_count: got %0d expected 2", bus.instr_count); end
    for (int i = 0; i < 6; i++) begin
      bus.run = ~bus.run;
      tick();
      n_checks++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || obs !== 19'd0) begin n_fail++; $display("FAIL ill_stuck_%0d: halted %b busy %b strobes %h expected 1/0/0", i, bus.halted, bus.busy, obs); end
    end
    bus.run = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.instr_count !== 8'd0) begin n_fail++; $display("FAIL ill_clear: flags %b%b count %0d expected 00/0", bus.halted, bus.illegal, bus.instr_count); end
  endtask

  task automatic test_halt_op();
    bus.IR = 32'hD800_0000; bus.run = 1'b1;
    repeat (5) tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.illegal !== 1'b0) begin n_fail++; $display("FAIL halt_flags: got %b%b expected 10", bus.halted, bus.illegal); end
    n_checks++; if (bus.instr_count !== 8'd1) begin n_fail++; $display("FAIL halt_count: got %0d expected 1", bus.instr_count); end
    bus.run = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_c;
    bus.IR = 32'hD000_0000; bus.run = 1'b1;
    tick();
    n_checks++; if (obs !== F_T0 || bus.instr_count !== 8'd0) begin n_fail++; $display("FAIL nop_first: strobes %h count %0d expected %h/0", obs, bus.instr_count, F_T0); end
    for (int i = 1; i <= 256; i++) begin
      repeat (4) tick();
      exp_c = 8'(i);
      n_checks++; if (obs !== F_T0 || bus.instr_count !== exp_c) begin n_fail++; $display("FAIL nop_b2b_%0d: strobes %h count %0d expected %h/%0d", i, obs, bus.instr_count, F_T0, exp_c); end
    end
    bus.run = 1'b0;
    repeat (4) tick();
    n_checks++; if (bus.busy !== 1'b0 || bus.instr_count !== 8'd1) begin n_fail++; $display("FAIL nop_end: busy %b count %0d expected 0/1", bus.busy, bus.instr_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_div_stall();
    test_clear_mid_stall();
    test_run_drop();
    test_illegal();
    test_halt_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
